gray_conv_arbiter: RTL and testbench

- Shares one registered binary-to-Gray conversion stage among NREQ requesters using round-robin arbitration.
- Each requester presents a binary word with a valid/ready handshake.
- The winner's word is converted (g = b ^ (b >> 1)) and registered into a single output slot, tagged with the requester ID.
- The output slot drains to a downstream consumer under valid/ready backpressure. The block sits between the requester front-ends and the shared Gray-code consumer (encoder/counter output path).

---
 rtl/gray_conv_arbiter.sv | 93 +++++++++
 tb/tb_gray_conv_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one registered binary-to-Gray conversion
// stage among NREQ requesters. The winner's word is converted, tagged with
// its requester index and held in a single output slot. The slot drains
// downstream under valid/ready backpressure. A saturating counter tracks
// the number of accepted conversions.
module gray_conv_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int CNT_W = 16,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_gray,
   output logic [ID_W-1:0]         out_id,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        conv_count
);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  win;
   logic [ID_W-1:0]  idx;
   logic             found;
   logic             can_accept;
   logic             grant;
   logic [WIDTH-1:0] sel_data;

   // The slot can take a new word when it is empty or being drained this cycle.
   assign can_accept = !out_valid || out_ready;

   // A grant needs a free slot, at least one valid requester, and reset released.
   assign grant = found && can_accept && !rst;

   // Search req_valid from ptr upward, wrapping (NREQ is a power of two).
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr + ID_W'(k);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Pick the winner's binary word out of the packed request bus.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == ID_W'(i)) begin
            sel_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept toward the winning requester only.
   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[win] = 1'b1;
      end
   end

   // Output slot, round-robin pointer and saturating conversion counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_gray   <= '0;
         out_id     <= '0;
         ptr        <= '0;
         conv_count <= '0;
      end else begin
         if (grant) begin
            out_gray  <= sel_data ^ (sel_data >> 1);
            out_id    <= win;
            out_valid <= 1'b1;
            ptr       <= win + ID_W'(1);
            if (conv_count != {CNT_W{1'b1}}) begin
               conv_count <= conv_count + CNT_W'(1);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter (NREQ=4, WIDTH=4, CNT_W=4).
// A stimulus process pushes hand-computed expected words into a scoreboard
// queue; a monitor pops and compares whenever the output slot drains.
module tb_gray_conv_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int CNT_W = 4;
   localparam int ID_W  = 2;

   typedef struct {
      logic [WIDTH-1:0] gray;
      logic [ID_W-1:0]  id;
   } sb_entry_t;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_gray;
   logic [ID_W-1:0]       out_id;
   logic                  out_ready;
   logic [CNT_W-1:0]      conv_count;

   sb_entry_t sb[$];
   int        compared;
   int        mismatched;

   gray_conv_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_gray   (out_gray),
      .out_id     (out_id),
      .out_ready  (out_ready),
      .conv_count (conv_count)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and record the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive all requester and downstream inputs at once.
   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*WIDTH-1:0] data,
                                input logic ready);
      req_valid = valid;
      req_data  = data;
      out_ready = ready;
   endtask

   task automatic pushExp(input logic [WIDTH-1:0] gray, input logic [ID_W-1:0] id);
      sb_entry_t e;
      e.gray = gray;
      e.id   = id;
      sb.push_back(e);
   endtask

   function automatic logic [WIDTH-1:0] grayOf(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Monitor: the slot is consumed on the next edge whenever valid and ready.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'd1, 32'd0);
         end else begin
            sb_entry_t e;
            e = sb.pop_front();
            checkOutput("out_gray", 32'(out_gray), 32'(e.gray));
            checkOutput("out_id", 32'(out_id), 32'(e.id));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [WIDTH-1:0] single_in  [4];
   logic [WIDTH-1:0] single_exp [4];
   logic [NREQ-1:0]  rr_ready   [6];

   initial begin
      compared   = 0;
      mismatched = 0;
      single_in  = '{4'b0101, 4'b1010, 4'b1111, 4'b0011};
      single_exp = '{4'b0111, 4'b1111, 4'b1000, 4'b0010};
      rr_ready   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      // Reset state, with requests present to show req_ready is gated.
      rst = 1'b1;
      applyStimulus(4'b0000, '0, 1'b0);
      #2;
      applyStimulus(4'b1111, 16'h3210, 1'b1);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_gray", 32'(out_gray), 32'd0);
      checkOutput("rst_out_id", 32'(out_id), 32'd0);
      checkOutput("rst_conv_count", 32'(conv_count), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b0000, '0, 1'b1);

      // Single requester 2, four words back to back.
      for (int i = 0; i < 4; i++) pushExp(single_exp[i], 2'd2);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         applyStimulus(4'b0100, {4'h0, single_in[i], 8'h00}, 1'b1);
         @(negedge clk);
         checkOutput("single_ready", 32'(req_ready), 32'b0100);
      end
      @(posedge clk); #1;
      applyStimulus(4'b0000, '0, 1'b1);
      @(negedge clk);
      checkOutput("single_count", 32'(conv_count), 32'd4);

      // Mid-cycle reset with a held word in the slot (ptr=3 wraps to req 0).
      @(posedge clk); #1;
      applyStimulus(4'b0001, 16'h0006, 1'b0);
      @(negedge clk);
      checkOutput("pre_rst_ready", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      applyStimulus(4'b0000, 16'h0006, 1'b0);
      @(negedge clk);
      checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
      checkOutput("pre_rst_gray", 32'(out_gray), 32'b0101);
      #2;
      rst = 1'b1;
      applyStimulus(4'b1111, 16'h3210, 1'b0);
      #1;
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_gray", 32'(out_gray), 32'd0);
      checkOutput("mid_rst_count", 32'(conv_count), 32'd0);
      checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b0000, '0, 1'b0);

      // Round robin: all four valid, grants 0,1,2,3,0,1.
      pushExp(4'b0000, 2'd0);
      pushExp(4'b0001, 2'd1);
      pushExp(4'b0011, 2'd2);
      pushExp(4'b0010, 2'd3);
      pushExp(4'b0000, 2'd0);
      pushExp(4'b0001, 2'd1);
      @(posedge clk); #1;
      applyStimulus(4'b1111, {4'b0011, 4'b0010, 4'b0001, 4'b0000}, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("rr_ready", 32'(req_ready), 32'(rr_ready[k]));
         @(posedge clk); #1;
      end
      applyStimulus(4'b0000, '0, 1'b1);
      @(negedge clk);
      checkOutput("rr_count", 32'(conv_count), 32'd6);
      @(posedge clk); #1;

      // Backpressure: req 1 sends 1000, slot held for 3 cycles, req 3 waits.
      pushExp(4'b1100, 2'd1);
      pushExp(4'b0100, 2'd3);
      applyStimulus(4'b0010, {4'b0111, 4'b0000, 4'b1000, 4'b0000}, 1'b0);
      @(negedge clk);
      checkOutput("bp_first_ready", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      applyStimulus(4'b1000, {4'b0111, 4'b0000, 4'b1000, 4'b0000}, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("bp_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_gray", 32'(out_gray), 32'b1100);
         checkOutput("bp_id", 32'(out_id), 32'd1);
         checkOutput("bp_ready", 32'(req_ready), 32'b0000);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_ready", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;

      // Pointer wrap: after req 3, req 0 and req 3 valid -> 0 then 3.
      pushExp(4'b1101, 2'd0);
      pushExp(4'b1001, 2'd3);
      applyStimulus(4'b1001, {4'b1110, 4'b0000, 4'b0000, 4'b1001}, 1'b1);
      @(negedge clk);
      checkOutput("wrap_ready0", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      applyStimulus(4'b1000, {4'b1110, 4'b0000, 4'b0000, 4'b1001}, 1'b1);
      @(negedge clk);
      checkOutput("wrap_ready3", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      applyStimulus(4'b0000, '0, 1'b1);
      @(negedge clk);
      checkOutput("wrap_count", 32'(conv_count), 32'd10);
      @(posedge clk); #1;
      checkOutput("sb_empty_mid", 32'(sb.size()), 32'd0);

      // Saturation: 17 conversions through a 4-bit counter.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int i = 0; i < 17; i++) pushExp(grayOf(4'(i)), 2'd1);
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         applyStimulus(4'b0010, {8'h00, 4'(i), 4'h0}, 1'b1);
         @(negedge clk);
         if (i == 15) checkOutput("sat_count15", 32'(conv_count), 32'hF);
      end
      @(posedge clk); #1;
      applyStimulus(4'b0000, '0, 1'b1);
      @(negedge clk);
      checkOutput("sat_count17", 32'(conv_count), 32'hF);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
